counter_inc_sched: RTL and testbench
====================================

# counter_inc_sched

Round-robin scheduler that time-shares one WIDTH-bit incrementer among NCH counter channels. Each channel requests an increment through a valid/ready handshake. The scheduler grants at most one channel per cycle, holds every channel's count register, and reports per-channel wrap-around. It sits between event sources and the counter datapath, replacing one incrementer per counter.

## Interface
- NCH, 4: number of counter channels (2..8)
- WIDTH, 8: count width per channel
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  NCH  per-channel increment request; level, held until accepted
- req_ready  out  NCH  one-hot-or-zero grant; an increment is accepted when req_valid[i] & req_ready[i]
- clr  in  NCH  per-channel synchronous clear; takes priority over increment
- count  out  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]; registered
- wrap  out  NCH  1-cycle pulse, registered; channel count went all-ones -> 0 by increment
- busy  out  1  any req_valid bit set this cycle (combinational OR)

## Operation
- Arbitration is combinational from req_valid and the registered pointer ptr (log2 NCH bits).
  - Search order is ptr, ptr+1, ..., ptr+NCH-1 (mod NCH).
  - The first channel with req_valid set gets req_ready. If no channel requests, req_ready = 0.
- Increment step, on the edge after acceptance of channel g: count[g] <= count[g] + 1, mod 2^WIDTH.
- If count[g] was 2^WIDTH-1, the step sets count[g] to 0 and wrap[g] = 1 for one cycle. Otherwise wrap = 0.
- Pointer update on acceptance: ptr <= g+1 mod NCH. With no acceptance, ptr holds.
- Clear, on each edge for every i with clr[i]: count[i] <= 0, with no wrap.
- Clear and grant on the same channel in the same cycle:
  - req_ready[i] is still asserted and the request is consumed.
  - The count ends at 0, wrap stays 0, and ptr still advances.
- Dropping req_valid before grant is legal and withdraws the request; nothing is recorded.
- No state machine beyond the pointer; every cycle is an independent arbitration.

## Timing
- Reset values: count = 0 for all channels, wrap = 0, ptr = 0, req_ready = 0 while reset is high.
- Grant latency: 0 cycles. req_ready responds in the same cycle as req_valid.
- Count update latency: 1 cycle after acceptance.
- Throughput: one increment per cycle in total. A channel holding req_valid continuously gets at most one increment every NCH cycles while all channels request.
- Fairness: worst-case wait from req_valid to grant is NCH-1 cycles.
- Reset asserted mid-operation:
  - All state clears immediately, even mid-cycle.
  - Requests pending at reset release are arbitrated from ptr = 0 on the first cycle.

## Structure
- Package counter_sched_pkg holds:
  - localparams DEF_NCH = 4 and DEF_WIDTH = 8
  - typedef chan_idx_t = logic [$clog2(DEF_NCH)-1:0]
  - function next_idx(idx, n) returning idx+1 mod n
- Sub-module rr_arbiter: combinational NCH-input round-robin grant from req and ptr, plus a registered ptr update.
- Top-level contents:
  - a single shared incrementer, muxed from count[g], with carry-out used as the wrap flag
  - the count register array
  - clear logic
  - the wrap register

## Test plan
- Reset, then channel 2 alone holds req_valid for 3 cycles:
  - req_ready = 0100 each cycle
  - count[2] goes 1, 2, 3; other channels stay 0
- All 4 channels hold req_valid from ptr = 0 for 8 cycles:
  - grants run 0, 1, 2, 3, 0, 1, 2, 3
  - each count = 2
- Channel 1 preset to 0xFF by 255 granted increments, then one more increment:
  - count[1] = 0x00 and wrap = 0010 for exactly one cycle
- Channel 3 has clr and req_valid together while count[3] = 0x05:
  - req_ready[3] = 1, count[3] = 0x00, wrap[3] = 0, ptr = 0
- Reset asserted asynchronously while channel 0 is granted with count[0] = 0x7F:
  - count[0] = 0 and ptr = 0 without a clock edge
  - after release, the next grant goes to the lowest requesting channel
- Channel 1 raises req_valid for one cycle while channel 0 is granted (ptr = 0), then drops it:
  - count[1] is unchanged
  - busy was 1 in that cycle

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  localparam int DEF_NCH   = 4;
  localparam int DEF_WIDTH = 8;

  typedef logic [$clog2(DEF_NCH)-1:0] chan_idx_t;

  // Wraps at n rather than at a power of two, so non-power-of-two NCH works.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant starting at ptr, with a registered pointer
// that moves past the winner on every grant.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int PW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] gnt_o,
  output logic [PW-1:0]  gnt_idx_o,
  output logic           gnt_vld_o
);

  logic [PW-1:0] ptr_q;
  logic [PW:0]   pos;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      pos = {1'b0, ptr_q} + (PW+1)'(k);
      if (pos >= (PW+1)'(NCH)) pos = pos - (PW+1)'(NCH);
      idx = pos[PW-1:0];
      // Grant is held low during reset so nothing is accepted while clearing.
      if (!gnt_vld_o && !reset && req_i[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ptr_q <= '0;
    else if (gnt_vld_o) ptr_q <= PW'(next_idx(32'(gnt_idx_o), NCH));
  end

endmodule

// File: rtl/counter_inc_sched.sv
// NCH counters sharing one incrementer; a round-robin arbiter picks which
// channel's request is served each cycle.
module counter_inc_sched
  import counter_sched_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       clr,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       wrap,
  output logic                 busy
);

  localparam int PW = $clog2(NCH);

  logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
  logic [NCH-1:0]            wrap_q, wrap_d;
  logic [PW-1:0]             gnt_idx;
  logic                      gnt_vld;
  logic [WIDTH-1:0]          sel_cnt;
  logic [WIDTH:0]            inc_w;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Single shared incrementer; its carry-out is the wrap flag.
  assign sel_cnt = count_q[gnt_idx];
  assign inc_w   = {1'b0, sel_cnt} + (WIDTH+1)'(1);

  always_comb begin
    count_d = count_q;
    wrap_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) begin
        count_d[i] = '0;
      end else if (gnt_vld && gnt_idx == PW'(i)) begin
        count_d[i] = inc_w[WIDTH-1:0];
        wrap_d[i]  = inc_w[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign busy  = |req_valid;

endmodule

// File: tb/tb_counter_inc_sched.sv
// Directed checks of the round-robin counter scheduler with hand-computed expectations.
module tb_counter_inc_sched;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] req_valid, req_ready, clr, wrap;
  logic [NCH*W-1:0] count;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  counter_inc_sched #(.NCH(NCH), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .clr       (clr),
    .count     (count),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int i);
    return count[i*W +: W];
  endfunction

  // Drive new inputs just after a falling edge so combinational outputs settle
  // before the next rising edge.
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] c);
    @(negedge clk);
    req_valid = v;
    clr       = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    clr       = '0;
    reset     = 1'b1;
    #2;
    reset     = 1'b0;
  endtask

  logic [NCH-1:0] exp_g;

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    clr       = '0;
    #3;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_wrap",  32'(wrap), 32'h0);
    check("rst_ptr",   32'(dut.u_arb.ptr_q), 32'h0);
    do_reset();

    // Channel 2 alone, three cycles.
    for (int k = 1; k <= 3; k++) begin
      drive(4'b0100, 4'b0000);
      check("solo_ready", 32'(req_ready), 32'h4);
      check("solo_busy",  32'(busy), 32'h1);
      tick();
      check("solo_cnt2", 32'(cnt(2)), 32'(k));
    end
    check("solo_others", 32'({cnt(3), cnt(1), cnt(0)}), 32'h0);

    // All channels requesting from ptr 0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 4'b0000);
      exp_g = 4'b0001 << (k % 4);
      check("rr_ready", 32'(req_ready), 32'(exp_g));
      tick();
    end
    check("rr_counts", 32'(count), 32'h02020202);

    // Channel 1 wrap-around.
    do_reset();
    for (int k = 0; k < 255; k++) begin
      drive(4'b0010, 4'b0000);
      tick();
    end
    check("pre_wrap_cnt", 32'(cnt(1)), 32'hFF);
    check("pre_wrap_flag", 32'(wrap), 32'h0);
    drive(4'b0010, 4'b0000);
    tick();
    check("wrap_cnt", 32'(cnt(1)), 32'h00);
    check("wrap_flag", 32'(wrap), 32'h2);
    drive(4'b0000, 4'b0000);
    tick();
    check("wrap_pulse_end", 32'(wrap), 32'h0);
    check("wrap_cnt_hold", 32'(cnt(1)), 32'h00);

    // Clear and grant together on channel 3.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1000, 4'b0000);
      tick();
    end
    check("clr_pre_cnt", 32'(cnt(3)), 32'h05);
    drive(4'b1000, 4'b1000);
    check("clr_ready", 32'(req_ready), 32'h8);
    tick();
    check("clr_cnt", 32'(cnt(3)), 32'h00);
    check("clr_wrap", 32'(wrap), 32'h0);
    check("clr_ptr", 32'(dut.u_arb.ptr_q), 32'h0);

    // Asynchronous reset while channel 0 is granted at 0x7F.
    do_reset();
    for (int k = 0; k < 127; k++) begin
      drive(4'b0001, 4'b0000);
      tick();
    end
    drive(4'b0001, 4'b0000);
    check("arst_pre_cnt", 32'(cnt(0)), 32'h7F);
    check("arst_pre_ready", 32'(req_ready), 32'h1);
    check("arst_pre_ptr", 32'(dut.u_arb.ptr_q), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("arst_cnt", 32'(cnt(0)), 32'h0);
    check("arst_ptr", 32'(dut.u_arb.ptr_q), 32'h0);
    check("arst_ready", 32'(req_ready), 32'h0);
    req_valid = 4'b1010;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_release_gnt", 32'(req_ready), 32'h2);
    tick();
    check("arst_release_cnt", 32'(cnt(1)), 32'h1);

    // Channel 1 requests for one cycle behind channel 0, then withdraws.
    do_reset();
    drive(4'b0011, 4'b0000);
    check("wd_ready", 32'(req_ready), 32'h1);
    check("wd_busy", 32'(busy), 32'h1);
    tick();
    drive(4'b0000, 4'b0000);
    check("wd_idle_ready", 32'(req_ready), 32'h0);
    check("wd_idle_busy", 32'(busy), 32'h0);
    tick();
    check("wd_cnt0", 32'(cnt(0)), 32'h1);
    check("wd_cnt1", 32'(cnt(1)), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
